parking_lot_controller: RTL
===========================

# parking_lot_controller

Parametrised, clocked successor to the combinational exit-slot decoder: tracks occupancy of `SLOTS` parking spaces, allocates the lowest free slot on entry, and releases a named slot on exit. Each direction has its own request/acknowledge handshake and timed gate-open output. It sits between the entry/exit sensor front-ends and the lot display/gate actuators.

## Interface
- `SLOTS`, default 8: number of parking spaces, 2..64.
- `IDX_W`, default `$clog2(SLOTS)`: slot index width.
- `CNT_W`, default `$clog2(SLOTS+1)`: free-count width.
- `GATE_CYCLES`, default 4: cycles a gate stays open after an accepted request, ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `enter_req`  in  1  level request for entry; held until `enter_ack` or `enter_deny`.
- `enter_ack`  out  1  one-cycle pulse: slot granted.
- `enter_deny`  out  1  one-cycle pulse: lot full.
- `enter_slot`  out  IDX_W  granted slot index; valid while `enter_ack`=1, holds value after.
- `gate_in_open`  out  1  entry gate drive.
- `exit_req`  in  1  level request for exit; held until `exit_ack` or `exit_err`.
- `exit_slot`  in  IDX_W  slot being vacated; stable while `exit_req`=1.
- `exit_ack`  out  1  one-cycle pulse: slot released.
- `exit_err`  out  1  one-cycle pulse: slot empty or index ≥ SLOTS.
- `gate_out_open`  out  1  exit gate drive.
- `occupancy`  out  SLOTS  bit i = 1 when slot i occupied.
- `free_count`  out  CNT_W  number of zero bits in `occupancy`.
- `full`, `empty`  out  1 each  `free_count`==0 / `free_count`==SLOTS.

## Operation
- Two independent FSMs, entry and exit, each with states IDLE, OPEN, WAIT_LOW.
- Entry IDLE, `enter_req`=1, not full: set lowest-index zero bit of `occupancy`, pulse `enter_ack`, drive `enter_slot`, go OPEN.
- Entry IDLE, `enter_req`=1, full: pulse `enter_deny`, go WAIT_LOW; no occupancy change.
- Exit IDLE, `exit_req`=1, `exit_slot` < SLOTS and occupied: clear that bit, pulse `exit_ack`, go OPEN.
- Exit IDLE, `exit_req`=1, slot empty or out of range: pulse `exit_err`, go WAIT_LOW.
- OPEN: gate output high; down-counter from GATE_CYCLES; on reaching 0 go WAIT_LOW.
- WAIT_LOW: stay until corresponding req is 0, then IDLE. A held request never produces a second response.
- Requests arriving while not in IDLE get no response until that FSM returns to IDLE.
- Simultaneous entry and exit in the same cycle: both served. Entry allocation and full check use `occupancy` as registered before that edge; a full lot with a concurrent exit denies the entry. Exit of the slot being allocated on the same edge cannot occur (slot was free ⇒ `exit_err`).
- `free_count`, `full`, `empty` derive combinationally from the `occupancy` register.

## Timing
- Request high before edge N while FSM in IDLE → ack/deny/err high in cycle after edge N (1-cycle latency), low after edge N+1.
- `occupancy` update takes effect at the same edge that raises the ack.
- `gate_*_open` rises at the ack edge, stays high exactly GATE_CYCLES cycles.
- Minimum entry-to-next-entry spacing: GATE_CYCLES + 2 cycles (ack edge, open, WAIT_LOW, IDLE) when req drops promptly.
- Reset (any time, including mid-OPEN): all outputs 0, `enter_slot`=0, `occupancy`=0, `free_count`=SLOTS, `empty`=1, `full`=0, both FSMs IDLE. First response possible one edge after `reset` deasserts.

## Configuration
- `PARK_STATS_EN` defined: adds outputs `total_entries` (16 bit) and `total_denies` (16 bit); increment on `enter_ack`/`enter_deny` edge, saturate at 16'hFFFF, cleared by `reset`.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset then `enter_req` high: `enter_ack` pulse with `enter_slot`=0, `occupancy`=8'h01, `free_count`=7, `gate_in_open` high 4 cycles.
- Eight sequential entries (SLOTS=8): slots 0..7 in order, `full`=1; ninth request → `enter_deny`, occupancy stays 8'hFF; holding req produces only one deny.
- From 8'hFF, exit slot 3 → `exit_ack`, occupancy 8'hF7; next entry gets slot 3.
- Exit of empty slot 5 on 8'h01 → `exit_err`, occupancy unchanged; SLOTS=6 with `exit_slot`=7 → `exit_err`.
- Full lot, `enter_req` and `exit_req` (slot 0) same cycle → `enter_deny` and `exit_ack` together, occupancy 8'hFE.
- `reset` asserted during OPEN → gate and occupancy immediately 0; with `PARK_STATS_EN`, counters read 0 after reset and saturate at 16'hFFFF.

Source files
------------

// File: rtl/parking_lot_controller.sv
// parking_lot_controller
//   Tracks occupancy of SLOTS parking spaces. On entry it hands out the lowest
//   free slot. On exit it releases the named slot. The entry and exit sides
//   each have their own req/ack handshake and a timed gate drive.
//
//   Parameters : SLOTS (2..64), IDX_W, CNT_W, GATE_CYCLES (>=1)
//   Ports      : clk, reset (async, active-high)
//                enter_req -> enter_ack / enter_deny / enter_slot / gate_in_open
//                exit_req, exit_slot -> exit_ack / exit_err / gate_out_open
//                occupancy, free_count, full, empty
//   Option     : PARK_STATS_EN adds total_entries / total_denies. These are
//                16-bit saturating counters of grants and denials.
//
//   Both FSMs (entry, exit):
//     state     | meaning
//     ST_IDLE   | waiting for a request; the only state that responds
//     ST_OPEN   | gate driven high, down-counter running
//     ST_WAIT_LOW | waiting for the request to drop before rearming
module parking_lot_controller #(
  parameter int SLOTS       = 8,
  parameter int IDX_W       = $clog2(SLOTS),
  parameter int CNT_W       = $clog2(SLOTS + 1),
  parameter int GATE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_req,
  output logic             enter_ack,
  output logic             enter_deny,
  output logic [IDX_W-1:0] enter_slot,
  output logic             gate_in_open,
  input  logic             exit_req,
  input  logic [IDX_W-1:0] exit_slot,
  output logic             exit_ack,
  output logic             exit_err,
  output logic             gate_out_open,
  output logic [SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
`ifdef PARK_STATS_EN
  output logic [15:0]      total_entries,
  output logic [15:0]      total_denies,
`endif
  output logic             empty
);

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_WAIT_LOW} state_t;

  // The timer is loaded with GATE_CYCLES-1 at the ack edge. The gate falls
  // on the edge where the timer is already 0, so it is high for exactly
  // GATE_CYCLES cycles.
  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  state_t             enter_state_q, enter_state_d;
  state_t             exit_state_q, exit_state_d;
  logic [TMR_W-1:0]   enter_tmr_q, enter_tmr_d;
  logic [TMR_W-1:0]   exit_tmr_q, exit_tmr_d;
  logic               enter_ack_q, enter_ack_d;
  logic               enter_deny_q, enter_deny_d;
  logic [IDX_W-1:0]   enter_slot_q, enter_slot_d;
  logic               gate_in_q, gate_in_d;
  logic               exit_ack_q, exit_ack_d;
  logic               exit_err_q, exit_err_d;
  logic               gate_out_q, gate_out_d;
  logic [SLOTS-1:0]   occupancy_q, occupancy_d;

  logic [IDX_W-1:0]   alloc_idx;
  logic [SLOTS-1:0]   alloc_mask;
  logic [SLOTS-1:0]   exit_mask;
  logic [SLOTS-1:0]   set_mask;
  logic [SLOTS-1:0]   clr_mask;
  logic               exit_hit;
  logic               lot_full;
  logic [CNT_W-1:0]   free_cnt;

`ifdef PARK_STATS_EN
  logic [15:0]        entries_q, entries_d;
  logic [15:0]        denies_q, denies_d;
`endif

  // Lowest free slot. An exit index at or above SLOTS matches no slot, so
  // exit_hit stays 0 and the request is answered with an error.
  always_comb begin
    alloc_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occupancy_q[i]) alloc_idx = IDX_W'(i);
    end
    alloc_mask = ~occupancy_q & (occupancy_q + SLOTS'(1));
    exit_hit   = 1'b0;
    exit_mask  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (exit_slot == IDX_W'(i)) begin
        exit_hit     = occupancy_q[i];
        exit_mask[i] = 1'b1;
      end
    end
    lot_full = &occupancy_q;
    free_cnt = '0;
    for (int i = 0; i < SLOTS; i++) begin
      free_cnt = free_cnt + {{(CNT_W-1){1'b0}}, ~occupancy_q[i]};
    end
  end

  always_comb begin
    enter_state_d = enter_state_q;
    enter_tmr_d   = enter_tmr_q;
    enter_ack_d   = 1'b0;
    enter_deny_d  = 1'b0;
    enter_slot_d  = enter_slot_q;
    gate_in_d     = gate_in_q;
    set_mask      = '0;
    case (enter_state_q)
      ST_IDLE: begin
        if (enter_req) begin
          if (!lot_full) begin
            set_mask      = alloc_mask;
            enter_ack_d   = 1'b1;
            enter_slot_d  = alloc_idx;
            gate_in_d     = 1'b1;
            enter_tmr_d   = TMR_LOAD;
            enter_state_d = ST_OPEN;
          end else begin
            enter_deny_d  = 1'b1;
            enter_state_d = ST_WAIT_LOW;
          end
        end
      end
      ST_OPEN: begin
        if (enter_tmr_q == '0) begin
          gate_in_d     = 1'b0;
          enter_state_d = ST_WAIT_LOW;
        end else begin
          enter_tmr_d = enter_tmr_q - TMR_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!enter_req) enter_state_d = ST_IDLE;
      end
      default: enter_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exit_state_d = exit_state_q;
    exit_tmr_d   = exit_tmr_q;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    gate_out_d   = gate_out_q;
    clr_mask     = '0;
    case (exit_state_q)
      ST_IDLE: begin
        if (exit_req) begin
          if (exit_hit) begin
            clr_mask     = exit_mask;
            exit_ack_d   = 1'b1;
            gate_out_d   = 1'b1;
            exit_tmr_d   = TMR_LOAD;
            exit_state_d = ST_OPEN;
          end else begin
            exit_err_d   = 1'b1;
            exit_state_d = ST_WAIT_LOW;
          end
        end
      end
      ST_OPEN: begin
        if (exit_tmr_q == '0) begin
          gate_out_d   = 1'b0;
          exit_state_d = ST_WAIT_LOW;
        end else begin
          exit_tmr_d = exit_tmr_q - TMR_W'(1);
        end
      end
      ST_WAIT_LOW: begin
        if (!exit_req) exit_state_d = ST_IDLE;
      end
      default: exit_state_d = ST_IDLE;
    endcase
  end

  // set_mask only ever targets a free slot and clr_mask an occupied one.
  // The two masks therefore never overlap.
  assign occupancy_d = (occupancy_q | set_mask) & ~clr_mask;

`ifdef PARK_STATS_EN
  always_comb begin
    entries_d = entries_q;
    denies_d  = denies_q;
    if (enter_ack_d && entries_q != 16'hFFFF) entries_d = entries_q + 16'd1;
    if (enter_deny_d && denies_q != 16'hFFFF) denies_d = denies_q + 16'd1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_state_q <= ST_IDLE;
      exit_state_q  <= ST_IDLE;
      enter_tmr_q   <= '0;
      exit_tmr_q    <= '0;
      enter_ack_q   <= 1'b0;
      enter_deny_q  <= 1'b0;
      enter_slot_q  <= '0;
      gate_in_q     <= 1'b0;
      exit_ack_q    <= 1'b0;
      exit_err_q    <= 1'b0;
      gate_out_q    <= 1'b0;
      occupancy_q   <= '0;
`ifdef PARK_STATS_EN
      entries_q     <= '0;
      denies_q      <= '0;
`endif
    end else begin
      enter_state_q <= enter_state_d;
      exit_state_q  <= exit_state_d;
      enter_tmr_q   <= enter_tmr_d;
      exit_tmr_q    <= exit_tmr_d;
      enter_ack_q   <= enter_ack_d;
      enter_deny_q  <= enter_deny_d;
      enter_slot_q  <= enter_slot_d;
      gate_in_q     <= gate_in_d;
      exit_ack_q    <= exit_ack_d;
      exit_err_q    <= exit_err_d;
      gate_out_q    <= gate_out_d;
      occupancy_q   <= occupancy_d;
`ifdef PARK_STATS_EN
      entries_q     <= entries_d;
      denies_q      <= denies_d;
`endif
    end
  end

  assign enter_ack     = enter_ack_q;
  assign enter_deny    = enter_deny_q;
  assign enter_slot    = enter_slot_q;
  assign gate_in_open  = gate_in_q;
  assign exit_ack      = exit_ack_q;
  assign exit_err      = exit_err_q;
  assign gate_out_open = gate_out_q;
  assign occupancy     = occupancy_q;
  assign free_count    = free_cnt;
  assign full          = (free_cnt == '0);
  assign empty         = (free_cnt == CNT_W'(SLOTS));
`ifdef PARK_STATS_EN
  assign total_entries = entries_q;
  assign total_denies  = denies_q;
`endif

endmodule
